// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the vending change path: FSM state encoding,
// fault codes and the 5-unit change encoding used by both the
// coin-accepting FSM and the change dispenser.
package change_dispenser_pkg;

    // Dispenser FSM states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DROP    = 3'd1,
        ST_SELECT  = 3'd2,
        ST_EJ_TEN  = 3'd3,
        ST_EJ_FIVE = 3'd4,
        ST_GAP     = 3'd5,
        ST_FAULT   = 3'd6
    } state_t;

    // Sticky fault causes reported on fault_code
    typedef enum logic [1:0] {
        FC_NONE    = 2'b00,
        FC_SHORT   = 2'b01,
        FC_JAM     = 2'b10,
        FC_OVERRUN = 2'b11
    } fault_code_t;

    // Change owed, counted in 5-units (bit2 = 20, bit1 = 10, bit0 = 5)
    localparam int CHG_W = 3;
    typedef logic [CHG_W-1:0] change_t;

    localparam change_t FIVE_UNITS = 3'd1;
    localparam change_t TEN_UNITS  = 3'd2;

    // True while a vend transaction is in flight (a new vend here is an overrun)
    function automatic logic is_dispensing(input state_t s);
        return (s != ST_IDLE) && (s != ST_FAULT);
    endfunction

endpackage

// File: rtl/change_dispenser_ack_timer.sv
// Hopper acknowledge watchdog. The count restarts in the first cycle of
// every wait state (start high) and expired flags the cycle in which the
// ACK_TIMEOUT-th consecutive cycle without the awaited ack level ends.
module ack_timer
    import change_dispenser_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic ack,
    output logic expired
);

    localparam int CNT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(ACK_TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt;

    // A start cycle counts as cycle zero of the new wait
    assign w_cnt   = start ? '0 : r_cnt;
    assign expired = !ack && (w_cnt >= LIMIT);

    // Saturating cycle counter for the current wait state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_cnt < LIMIT) begin
            r_cnt <= w_cnt + CNT_W'(1);
        end else begin
            r_cnt <= w_cnt;
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: releases the drink, then pays out the change owed
// using ten-coins first and five-coins second, handshaking each coin with
// the shared hopper acknowledge. Short change, hopper jams and overlapping
// vend requests end in a sticky FAULT state cleared by clr_fault.
module change_dispenser
    import change_dispenser_pkg::*;
#(
    parameter int INV_W       = 6,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vend,
    input  logic [2:0]       change,
    input  logic             hopper_ack,
    input  logic             load,
    input  logic [INV_W-1:0] load_five,
    input  logic [INV_W-1:0] load_ten,
    input  logic             clr_fault,
    output logic             drink,
    output logic             eject_five,
    output logic             eject_ten,
    output logic             busy,
    output logic             exact_change,
    output logic             fault,
    output logic [1:0]       fault_code
);

    state_t           r_state;
    change_t          r_rem;
    logic [INV_W-1:0] r_five_cnt;
    logic [INV_W-1:0] r_ten_cnt;
    logic             r_drink;
    logic             r_ej_five;
    logic             r_ej_ten;
    logic             r_busy;
    logic             r_exact;
    logic             r_fault;
    fault_code_t      r_fault_code;
    logic             r_ovr;
    logic             r_tmr_start;

    logic             w_tmr_ack;
    logic             w_expired;
    logic             w_overrun;
    logic             w_ld_ok;

    // Inventory decrement that holds at zero instead of wrapping
    function automatic logic [INV_W-1:0] sat_dec(input logic [INV_W-1:0] v);
        return (v == '0) ? v : v - 1'b1;
    endfunction

    // In GAP the awaited event is the ack falling; elsewhere it is the ack rising
    assign w_tmr_ack = (r_state == ST_GAP) ? !hopper_ack : hopper_ack;
    assign w_overrun = vend && is_dispensing(r_state);
    assign w_ld_ok   = load && ((r_state == ST_IDLE) || (r_state == ST_FAULT));

    ack_timer #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_ack_timer (
        .clk     (clk),
        .rst     (rst),
        .start   (r_tmr_start),
        .ack     (w_tmr_ack),
        .expired (w_expired)
    );

    // Dispenser FSM with inventories and all registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_rem        <= '0;
            r_five_cnt   <= '0;
            r_ten_cnt    <= '0;
            r_drink      <= 1'b0;
            r_ej_five    <= 1'b0;
            r_ej_ten     <= 1'b0;
            r_busy       <= 1'b0;
            r_exact      <= 1'b1;
            r_fault      <= 1'b0;
            r_fault_code <= FC_NONE;
            r_ovr        <= 1'b0;
            r_tmr_start  <= 1'b0;
        end else begin
            r_drink     <= 1'b0;
            r_tmr_start <= 1'b0;

            if (w_ld_ok) begin
                r_five_cnt <= load_five;
                r_ten_cnt  <= load_ten;
                r_exact    <= (load_five == '0);
            end

            // A vend during a transaction is flagged now; the FSM parks in
            // FAULT once the current payout has finished.
            if (w_overrun) begin
                r_ovr        <= 1'b1;
                r_fault      <= 1'b1;
                r_fault_code <= FC_OVERRUN;
            end

            case (r_state)
                ST_IDLE: begin
                    if (vend) begin
                        r_rem   <= change;
                        r_state <= ST_DROP;
                        r_drink <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end

                ST_DROP: begin
                    r_state <= ST_SELECT;
                end

                ST_SELECT: begin
                    if (r_rem == '0) begin
                        if (r_ovr || w_overrun) begin
                            r_state <= ST_FAULT;
                            r_ovr   <= 1'b0;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else if ((r_rem >= TEN_UNITS) && (r_ten_cnt != '0)) begin
                        r_state     <= ST_EJ_TEN;
                        r_ej_ten    <= 1'b1;
                        r_tmr_start <= 1'b1;
                    end else if ((r_rem >= FIVE_UNITS) && (r_five_cnt != '0)) begin
                        r_state     <= ST_EJ_FIVE;
                        r_ej_five   <= 1'b1;
                        r_tmr_start <= 1'b1;
                    end else begin
                        r_state      <= ST_FAULT;
                        r_rem        <= '0;
                        r_ovr        <= 1'b0;
                        r_fault      <= 1'b1;
                        r_fault_code <= FC_SHORT;
                    end
                end

                ST_EJ_TEN: begin
                    if (hopper_ack) begin
                        r_rem       <= r_rem - TEN_UNITS;
                        r_ten_cnt   <= sat_dec(r_ten_cnt);
                        r_ej_ten    <= 1'b0;
                        r_state     <= ST_GAP;
                        r_tmr_start <= 1'b1;
                    end else if (w_expired) begin
                        r_ej_ten     <= 1'b0;
                        r_state      <= ST_FAULT;
                        r_rem        <= '0;
                        r_ovr        <= 1'b0;
                        r_fault      <= 1'b1;
                        r_fault_code <= FC_JAM;
                    end
                end

                ST_EJ_FIVE: begin
                    if (hopper_ack) begin
                        r_rem       <= r_rem - FIVE_UNITS;
                        r_five_cnt  <= sat_dec(r_five_cnt);
                        r_exact     <= (sat_dec(r_five_cnt) == '0);
                        r_ej_five   <= 1'b0;
                        r_state     <= ST_GAP;
                        r_tmr_start <= 1'b1;
                    end else if (w_expired) begin
                        r_ej_five    <= 1'b0;
                        r_state      <= ST_FAULT;
                        r_rem        <= '0;
                        r_ovr        <= 1'b0;
                        r_fault      <= 1'b1;
                        r_fault_code <= FC_JAM;
                    end
                end

                ST_GAP: begin
                    if (!hopper_ack) begin
                        r_state <= ST_SELECT;
                    end else if (w_expired) begin
                        r_state      <= ST_FAULT;
                        r_rem        <= '0;
                        r_ovr        <= 1'b0;
                        r_fault      <= 1'b1;
                        r_fault_code <= FC_JAM;
                    end
                end

                ST_FAULT: begin
                    r_ej_five <= 1'b0;
                    r_ej_ten  <= 1'b0;
                    r_rem     <= '0;
                    if (clr_fault) begin
                        r_state      <= ST_IDLE;
                        r_busy       <= 1'b0;
                        r_fault      <= 1'b0;
                        r_fault_code <= FC_NONE;
                        r_ovr        <= 1'b0;
                    end
                end

                default: begin
                    r_state   <= ST_IDLE;
                    r_busy    <= 1'b0;
                    r_ej_five <= 1'b0;
                    r_ej_ten  <= 1'b0;
                end
            endcase
        end
    end

    assign drink        = r_drink;
    assign eject_five   = r_ej_five;
    assign eject_ten    = r_ej_ten;
    assign busy         = r_busy;
    assign exact_change = r_exact;
    assign fault        = r_fault;
    assign fault_code   = r_fault_code;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: hopper model with a fixed ack delay,
// output event counters, and hand-computed expectations per scenario.
module tb_change_dispenser;
    import change_dispenser_pkg::*;

    localparam int INV_W   = 6;
    localparam int TMO     = 8;
    localparam int HOP_DLY = 3;

    logic             clk        = 1'b0;
    logic             rst        = 1'b1;
    logic             vend       = 1'b0;
    logic [2:0]       change     = 3'd0;
    logic             hopper_ack = 1'b0;
    logic             load       = 1'b0;
    logic [INV_W-1:0] load_five  = '0;
    logic [INV_W-1:0] load_ten   = '0;
    logic             clr_fault  = 1'b0;
    logic             drink;
    logic             eject_five;
    logic             eject_ten;
    logic             busy;
    logic             exact_change;
    logic             fault;
    logic [1:0]       fault_code;

    int n_chk  = 0;
    int n_pass = 0;

    bit hop_en  = 1'b0;
    int hop_cnt = 0;

    int   n_drink    = 0;
    int   n_five_req = 0;
    int   n_ten_req  = 0;
    int   n_five_cyc = 0;
    int   n_both     = 0;
    logic prev_five  = 1'b0;
    logic prev_ten   = 1'b0;

    change_dispenser #(
        .INV_W       (INV_W),
        .ACK_TIMEOUT (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .vend         (vend),
        .change       (change),
        .hopper_ack   (hopper_ack),
        .load         (load),
        .load_five    (load_five),
        .load_ten     (load_ten),
        .clr_fault    (clr_fault),
        .drink        (drink),
        .eject_five   (eject_five),
        .eject_ten    (eject_ten),
        .busy         (busy),
        .exact_change (exact_change),
        .fault        (fault),
        .fault_code   (fault_code)
    );

    always #5 clk = ~clk;

    // Hopper: acks a request on the third negedge it is seen, drops ack once the request goes low
    always @(negedge clk) begin
        if (!hop_en || rst || !(eject_five || eject_ten)) begin
            hopper_ack = 1'b0;
            hop_cnt    = 0;
        end else if (hop_cnt == HOP_DLY - 1) begin
            hopper_ack = 1'b1;
        end else begin
            hop_cnt = hop_cnt + 1;
        end
    end

    // Output event counters
    always @(negedge clk) begin
        if (drink) n_drink = n_drink + 1;
        if (eject_five && !prev_five) n_five_req = n_five_req + 1;
        if (eject_ten && !prev_ten) n_ten_req = n_ten_req + 1;
        if (eject_five) n_five_cyc = n_five_cyc + 1;
        if (eject_five && eject_ten) n_both = n_both + 1;
        prev_five = eject_five;
        prev_ten  = eject_ten;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_chk = n_chk + 1;
        if (got == exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic do_load(input int lf, input int lt);
        @(posedge clk); #1;
        load      = 1'b1;
        load_five = INV_W'(lf);
        load_ten  = INV_W'(lt);
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    task automatic do_vend(input logic [2:0] c);
        @(posedge clk); #1;
        vend   = 1'b1;
        change = c;
        @(posedge clk); #1;
        vend = 1'b0;
    endtask

    task automatic do_clr();
        @(posedge clk); #1;
        clr_fault = 1'b1;
        @(posedge clk); #1;
        clr_fault = 1'b0;
    endtask

    task automatic wait_settled(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (dut.r_state == ST_IDLE || dut.r_state == ST_FAULT) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_eject(input bit ten, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (ten ? eject_ten : eject_five) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        int d0;
        int f0;
        int t0;
        int c0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_drink", drink, 0);
        check("rst_eject", {eject_ten, eject_five}, 0);
        check("rst_fault", fault, 0);
        check("rst_code", fault_code, 0);
        check("rst_exact", exact_change, 1);
        rst    = 1'b0;
        hop_en = 1'b1;

        // Test 1: 4/4 stock, change 15 -> one ten then one five
        do_load(4, 4);
        d0 = n_drink; f0 = n_five_req; t0 = n_ten_req;
        do_vend(3'b011);
        check("t1_drink_on", drink, 1);
        @(posedge clk); #1;
        check("t1_drink_off", drink, 0);
        check("t1_busy", busy, 1);
        wait_eject(1'b1, 20, ok);
        check("t1_ten_seen", ok, 1);
        load = 1'b1; load_five = 6'd20; load_ten = 6'd20;
        @(posedge clk); #1;
        load = 1'b0;
        wait_settled(60, ok);
        check("t1_done", ok, 1);
        check("t1_state", int'(dut.r_state), int'(ST_IDLE));
        check("t1_busy_end", busy, 0);
        check("t1_drinks", n_drink - d0, 1);
        check("t1_tens", n_ten_req - t0, 1);
        check("t1_fives", n_five_req - f0, 1);
        check("t1_five_cnt", dut.r_five_cnt, 3);
        check("t1_ten_cnt", dut.r_ten_cnt, 3);
        check("t1_fault", fault, 0);

        // Test 2: load 4/0 together with vend of 20 -> four fives
        f0 = n_five_req; t0 = n_ten_req;
        @(posedge clk); #1;
        load = 1'b1; load_five = 6'd4; load_ten = 6'd0;
        vend = 1'b1; change = 3'b100;
        @(posedge clk); #1;
        load = 1'b0; vend = 1'b0;
        wait_settled(80, ok);
        check("t2_done", ok, 1);
        check("t2_fives", n_five_req - f0, 4);
        check("t2_tens", n_ten_req - t0, 0);
        check("t2_five_cnt", dut.r_five_cnt, 0);
        check("t2_exact", exact_change, 1);
        check("t2_fault", fault, 0);

        // Test 3: 1/0 stock, change 15 -> one five then short-change fault
        do_load(1, 0);
        f0 = n_five_req;
        do_vend(3'b011);
        wait_settled(60, ok);
        check("t3_done", ok, 1);
        check("t3_fives", n_five_req - f0, 1);
        check("t3_state", int'(dut.r_state), int'(ST_FAULT));
        check("t3_fault", fault, 1);
        check("t3_code", fault_code, 1);
        check("t3_eject", {eject_ten, eject_five}, 0);
        do_clr();
        check("t3_clr_state", int'(dut.r_state), int'(ST_IDLE));
        check("t3_clr_busy", busy, 0);
        check("t3_clr_fault", fault, 0);
        check("t3_clr_code", fault_code, 0);

        // Test 4: no ack -> eject held 8 cycles then jam fault
        hop_en = 1'b0;
        do_load(4, 4);
        c0 = n_five_cyc;
        do_vend(3'b001);
        wait_settled(40, ok);
        check("t4_done", ok, 1);
        check("t4_eject_cycles", n_five_cyc - c0, 8);
        check("t4_state", int'(dut.r_state), int'(ST_FAULT));
        check("t4_code", fault_code, 2);
        check("t4_eject", {eject_ten, eject_five}, 0);
        check("t4_five_cnt", dut.r_five_cnt, 4);
        do_load(2, 1);
        check("t4_load_in_fault", dut.r_ten_cnt, 1);
        do_clr();
        hop_en = 1'b1;

        // Test 5: second vend during EJ_TEN -> payout completes, then overrun fault
        d0 = n_drink; f0 = n_five_req; t0 = n_ten_req;
        do_vend(3'b010);
        wait_eject(1'b1, 20, ok);
        check("t5_ten_seen", ok, 1);
        vend = 1'b1; change = 3'b011;
        @(posedge clk); #1;
        vend = 1'b0;
        check("t5_fault_now", fault, 1);
        check("t5_code_now", fault_code, 3);
        check("t5_still_ejecting", eject_ten, 1);
        wait_settled(60, ok);
        check("t5_done", ok, 1);
        check("t5_state", int'(dut.r_state), int'(ST_FAULT));
        check("t5_code", fault_code, 3);
        check("t5_tens", n_ten_req - t0, 1);
        check("t5_fives", n_five_req - f0, 0);
        check("t5_drinks", n_drink - d0, 1);
        check("t5_ten_cnt", dut.r_ten_cnt, 0);
        do_clr();

        // Test 6: asynchronous reset during EJ_FIVE
        do_vend(3'b001);
        wait_eject(1'b0, 20, ok);
        check("t6_five_seen", ok, 1);
        #1 rst = 1'b1;
        #1;
        check("t6_async_eject", {eject_ten, eject_five}, 0);
        check("t6_async_busy", busy, 0);
        check("t6_async_exact", exact_change, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("t6_state", int'(dut.r_state), int'(ST_IDLE));
        check("t6_busy", busy, 0);
        check("t6_five_cnt", dut.r_five_cnt, 0);

        check("no_dual_eject", n_both, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 The block SHALL have parameter INV_W, default 6, meaning the width of each coin-inventory counter.
REQ-002 The block SHALL have parameter ACK_TIMEOUT, default 255, meaning the maximum number of cycles to wait for a hopper acknowledge.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port vend, input, 1 bit: one-cycle request from the coin-accepting FSM to serve a drink.
REQ-006 The block SHALL have port change, input, 3 bits: change owed, sampled with vend. Bit2 is 20, bit1 is 10, bit0 is 5; equivalently, an unsigned count of 5-units.
REQ-007 The block SHALL have port hopper_ack, input, 1 bit: coin-ejected acknowledge, shared by both hoppers.
REQ-008 The block SHALL have port load, input, 1 bit: inventory reload strobe.
REQ-009 The block SHALL have ports load_five and load_ten, input, INV_W bits each: reload values.
REQ-010 The block SHALL have port clr_fault, input, 1 bit: clears a sticky fault.
REQ-011 The block SHALL have port drink, output, 1 bit: one-cycle drink-release pulse.
REQ-012 The block SHALL have ports eject_five and eject_ten, output, 1 bit each: level requests to the 5 and 10 hoppers.
REQ-013 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not IDLE.
REQ-014 The block SHALL have port exact_change, output, 1 bit: high while the five-coin inventory is 0.
REQ-015 The block SHALL have port fault, output, 1 bit, and port fault_code, output, 2 bits: 01 = short change, 10 = hopper jam, 11 = vend overrun.

Function
REQ-016 The FSM SHALL have the states IDLE, DROP, SELECT, EJ_TEN, EJ_FIVE, GAP and FAULT.
REQ-017 In IDLE, vend=1 SHALL latch change into the 3-bit register rem and move to DROP; drink is high for exactly the DROP cycle (vend at cycle N gives drink at N+1).
REQ-018 DROP SHALL go to SELECT unconditionally.
REQ-019 SELECT SHALL apply these rules in priority order:
- rem=0: go to IDLE.
- rem>=2 and ten_cnt>0: go to EJ_TEN.
- rem>=1 and five_cnt>0: go to EJ_FIVE.
- otherwise: go to FAULT with code 01.
REQ-020 EJ_TEN and EJ_FIVE SHALL hold their eject output high until hopper_ack is sampled high. On that edge the block SHALL subtract 2 or 1 from rem, decrement the matching inventory, and go to GAP.
REQ-021 GAP SHALL drive both eject outputs low, wait until hopper_ack is low, then go to SELECT.
REQ-022 A wait counter SHALL reset on entry to each of EJ_TEN, EJ_FIVE and GAP. If it reaches ACK_TIMEOUT, the FSM SHALL go to FAULT with code 10.
REQ-023 vend sampled high while busy SHALL be ignored for dispensing and SHALL set fault_code 11 with fault=1. The current transaction completes, and the FSM then enters FAULT instead of IDLE.
REQ-024 FAULT SHALL be sticky: both eject outputs low and fault=1.
- clr_fault returns the FSM to IDLE and zeroes fault_code.
- rem is discarded.
REQ-025 load SHALL be honoured only in IDLE or FAULT and sets both inventories from the load inputs. load in any other state is ignored.
REQ-026 If load and vend are both high in IDLE, load SHALL take effect and vend SHALL also be accepted; SELECT sees the loaded inventories.
REQ-027 Inventory counters SHALL saturate at 0 and SHALL never wrap.
REQ-028 Only one of eject_five and eject_ten SHALL be high in any cycle.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 While rst is high, the FSM SHALL be IDLE and rem, the wait counter, fault_code, drink, eject_five, eject_ten, busy and fault SHALL all be 0.
REQ-031 While rst is high, both inventories SHALL be 0, so exact_change=1 after reset.
REQ-032 rst asserted mid-eject SHALL drop the eject outputs immediately (asynchronously) and SHALL abandon the transaction.

Structure
REQ-033 The state encoding, the fault_code constants and the 5-unit change encoding SHALL live in a shared package, reused by the coin-accepting FSM.
REQ-034 The ack timeout counter SHALL be one sub-module, ack_timer, with inputs start and ack and output expired; everything else SHALL be flat.

Verification
REQ-035 Test 1: load 4/4, then vend with change=3'b011; the hopper acks each request after 3 cycles. Required: drink pulse, then eject_ten once, then eject_five once, then busy low; inventories end at 3/3.
REQ-036 Test 2: inventories five=4, ten=0, then vend with change=3'b100. Required: four eject_five cycles, and five_cnt=0 with exact_change=1.
REQ-037 Test 3: inventories five=1, ten=0, then vend with change=3'b011. Required: one five coin ejected, then fault=1 with fault_code=01; after clr_fault, the FSM is IDLE.
REQ-038 Test 4: hopper_ack held at 0 with ACK_TIMEOUT=8. Required: eject held for 8 cycles, then fault_code=10 and eject outputs low.
REQ-039 Test 5: a second vend during EJ_TEN. Required: the first transaction completes, then fault_code=11.
REQ-040 Test 6: rst pulsed during EJ_FIVE. Required: outputs zero without waiting for a clock edge, and IDLE after release.
